// File: rtl/memory_access_stage_pkg.sv
// Shared definitions for the MEM stage: CONTROL bit positions, the data-memory
// request state encoding and a small alignment helper.
package memory_access_stage_pkg;

  // CONTROL bus bit positions as produced by the EX stage
  localparam int CTRL_REG_WRITE  = 4;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_BRANCH     = 2;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 0;

  // Data-memory request states
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_t;

  // Word accesses only: any set bit in the two LSBs is a misaligned address
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/memory_access_stage_dmem_request_fsm.sv
// Data-memory request sequencer for the MEM stage.
// Holds the IDLE/ACCESS state, the timeout counter and the registered write
// enable. Outputs are decoded purely from state so nothing combinational
// reaches STALL or MEM_REQ from the memory acknowledge.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        accept an aligned load/store this cycle (only honoured in IDLE)
//   wr           1 = the accepted access is a write
//   mem_ack      one-cycle completion pulse from data memory
//   mem_req      request asserted for every ACCESS cycle
//   mem_we       write enable, valid with mem_req
//   stall        1 while an access is open
//   done         ACK seen in ACCESS this cycle
//   abort        timeout limit reached this cycle without ACK
module dmem_request_fsm
  import memory_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic wr,
  input  logic mem_ack,
  output logic mem_req,
  output logic mem_we,
  output logic stall,
  output logic done,
  output logic abort
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // MEM_ACK while idle is deliberately ignored
        if (start) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
          we_d    = wr;
        end
      end
      ST_ACCESS: begin
        // cnt_q counts completed ACCESS cycles without ACK; the cycle in which
        // it would reach the limit is the last one. ACK in that cycle wins.
        if (mem_ack) begin
          done    = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req = (state_q == ST_ACCESS);
  assign mem_we  = mem_req & we_q;
  assign stall   = (state_q != ST_IDLE);

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage of the 32-bit RISC pipeline.
// Latches EX-stage outputs, runs loads/stores against a multi-cycle data
// memory via REQ/ACK, stalls upstream while an access is open, and drives the
// registered MEM/WB outputs plus the branch decision back to fetch.
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   IN_VALID, ALU_RESULT, WRITE_DATA, WRITE_REGISTER, BRANCH_TARGET, ZERO,
//   CONTROL, HIT                  EX-stage outputs
//   STALL                         upstream must hold its inputs
//   MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_RDATA, MEM_ACK
//                                 data-memory handshake
//   OUT_VALID, READ_DATA, ALU_RESULT_OUT, WRITE_REG_OUT, CONTROL_OUT,
//   PC_SRC, BRANCH_TGT_OUT, HIT_OUT   registered MEM/WB outputs
//   ERROR                         sticky timeout/misalignment flag
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] ALU_RESULT,
  input  logic [DATA_W-1:0] WRITE_DATA,
  input  logic [4:0]        WRITE_REGISTER,
  input  logic [DATA_W-1:0] BRANCH_TARGET,
  input  logic              ZERO,
  input  logic [4:0]        CONTROL,
  input  logic              HIT,
  output logic              STALL,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_ACK,
  output logic              OUT_VALID,
  output logic [DATA_W-1:0] READ_DATA,
  output logic [DATA_W-1:0] ALU_RESULT_OUT,
  output logic [4:0]        WRITE_REG_OUT,
  output logic [1:0]        CONTROL_OUT,
  output logic              PC_SRC,
  output logic [DATA_W-1:0] BRANCH_TGT_OUT,
  output logic              HIT_OUT,
  output logic              ERROR
);

  logic stall, done, abort;
  logic accept, is_mem, misaligned, start;

  assign accept     = IN_VALID & ~stall;
  assign is_mem     = CONTROL[CTRL_MEM_READ] | CONTROL[CTRL_MEM_WRITE];
  assign misaligned = is_misaligned(ALU_RESULT[1:0]);
  assign start      = accept & is_mem & ~misaligned;

  // READ+WRITE together is handled as a store, so MEM_WRITE alone decides the direction
  dmem_request_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .clk    (CLK),
    .rst    (RST),
    .start  (start),
    .wr     (CONTROL[CTRL_MEM_WRITE]),
    .mem_ack(MEM_ACK),
    .mem_req(MEM_REQ),
    .mem_we (MEM_WE),
    .stall  (stall),
    .done   (done),
    .abort  (abort)
  );

  // ---- p0: EX/MEM latch, held for the duration of an access ----
  logic [DATA_W-1:0] addr_p0, wdata_p0, tgt_p0;
  logic [4:0]        wreg_p0, ctrl_p0;
  logic              zero_p0, hit_p0;
  logic              load_p0;

  assign load_p0 = ctrl_p0[CTRL_MEM_READ] & ~ctrl_p0[CTRL_MEM_WRITE];

  // ---- p1: MEM/WB output register ----
  logic [DATA_W-1:0] rdata_p1, alu_p1, tgt_p1;
  logic [4:0]        wreg_p1;
  logic [1:0]        ctrl_p1;
  logic              pc_src_p1, hit_p1, vld_p1, error_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_p0   <= '0;
      wdata_p0  <= '0;
      tgt_p0    <= '0;
      wreg_p0   <= '0;
      ctrl_p0   <= '0;
      zero_p0   <= 1'b0;
      hit_p0    <= 1'b0;
      rdata_p1  <= '0;
      alu_p1    <= '0;
      tgt_p1    <= '0;
      wreg_p1   <= '0;
      ctrl_p1   <= '0;
      pc_src_p1 <= 1'b0;
      hit_p1    <= 1'b0;
      vld_p1    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      // OUT_VALID and PC_SRC are single-cycle pulses
      vld_p1    <= 1'b0;
      pc_src_p1 <= 1'b0;

      if (start) begin
        addr_p0  <= ALU_RESULT;
        wdata_p0 <= WRITE_DATA;
        tgt_p0   <= BRANCH_TARGET;
        wreg_p0  <= WRITE_REGISTER;
        ctrl_p0  <= CONTROL;
        zero_p0  <= ZERO;
        hit_p0   <= HIT;
      end

      if (accept && !start) begin
        // Non-memory instruction, or a misaligned access that never issues a request
        rdata_p1  <= '0;
        alu_p1    <= ALU_RESULT;
        tgt_p1    <= BRANCH_TARGET;
        wreg_p1   <= WRITE_REGISTER;
        ctrl_p1   <= {CONTROL[CTRL_REG_WRITE] & ~is_mem, CONTROL[CTRL_MEM_TO_REG]};
        pc_src_p1 <= CONTROL[CTRL_BRANCH] & ZERO;
        hit_p1    <= HIT;
        vld_p1    <= 1'b1;
        if (is_mem) error_q <= 1'b1;
      end else if (done || abort) begin
        rdata_p1  <= (done && load_p0) ? MEM_RDATA : '0;
        alu_p1    <= addr_p0;
        tgt_p1    <= tgt_p0;
        wreg_p1   <= wreg_p0;
        ctrl_p1   <= {ctrl_p0[CTRL_REG_WRITE] & ~abort, ctrl_p0[CTRL_MEM_TO_REG]};
        pc_src_p1 <= ctrl_p0[CTRL_BRANCH] & zero_p0;
        hit_p1    <= hit_p0;
        vld_p1    <= 1'b1;
        if (abort) error_q <= 1'b1;
      end
    end
  end

  assign STALL          = stall;
  assign MEM_ADDR       = addr_p0;
  assign MEM_WDATA      = wdata_p0;
  assign OUT_VALID      = vld_p1;
  assign READ_DATA      = rdata_p1;
  assign ALU_RESULT_OUT = alu_p1;
  assign WRITE_REG_OUT  = wreg_p1;
  assign CONTROL_OUT    = ctrl_p1;
  assign PC_SRC         = pc_src_p1;
  assign BRANCH_TGT_OUT = tgt_p1;
  assign HIT_OUT        = hit_p1;
  assign ERROR          = error_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: the driver issues instructions,
// plays the data memory, and pushes the expected MEM/WB result; an
// independent monitor pops and compares whenever OUT_VALID is seen.
module tb_memory_access_stage;

  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic [31:0] ALU_RESULT = '0, WRITE_DATA = '0, BRANCH_TARGET = '0, MEM_RDATA = '0;
  logic [4:0]  WRITE_REGISTER = '0, CONTROL = '0;
  logic        ZERO = 1'b0, HIT = 1'b0, MEM_ACK = 1'b0;
  logic        STALL, MEM_REQ, MEM_WE, OUT_VALID, PC_SRC, HIT_OUT, ERROR;
  logic [31:0] MEM_ADDR, MEM_WDATA, READ_DATA, ALU_RESULT_OUT, BRANCH_TGT_OUT;
  logic [4:0]  WRITE_REG_OUT;
  logic [1:0]  CONTROL_OUT;

  memory_access_stage dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .ALU_RESULT(ALU_RESULT),
    .WRITE_DATA(WRITE_DATA), .WRITE_REGISTER(WRITE_REGISTER),
    .BRANCH_TARGET(BRANCH_TARGET), .ZERO(ZERO), .CONTROL(CONTROL), .HIT(HIT),
    .STALL(STALL), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
    .OUT_VALID(OUT_VALID), .READ_DATA(READ_DATA), .ALU_RESULT_OUT(ALU_RESULT_OUT),
    .WRITE_REG_OUT(WRITE_REG_OUT), .CONTROL_OUT(CONTROL_OUT), .PC_SRC(PC_SRC),
    .BRANCH_TGT_OUT(BRANCH_TGT_OUT), .HIT_OUT(HIT_OUT), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [1:0]  ctl;
    logic        pc;
    logic [31:0] tgt;
    logic        hit;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   err_model = 1'b0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Monitor: compares every OUT_VALID against the oldest expectation
  initial begin
    exp_t e, a;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (OUT_VALID === 1'b1) begin
          a = '{READ_DATA, ALU_RESULT_OUT, WRITE_REG_OUT, CONTROL_OUT, PC_SRC,
                BRANCH_TGT_OUT, HIT_OUT, ERROR};
          n_checks++;
          if (sb.size() == 0) begin
            $display("FAIL unexpected_out_valid: got OUT_VALID=1 expected no output, result 0x%0h", a);
          end else begin
            e = sb.pop_front();
            if (a === e) n_pass++;
            else $display("FAIL memwb_result: got 0x%0h expected 0x%0h", a, e);
          end
        end else begin
          chk("pc_src_idle", {63'd0, PC_SRC}, 64'd0);
        end
      end
    end
  end

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK); @(negedge CLK);
    RST = 1'b0;
    err_model = 1'b0;
    chk("error_after_reset", {63'd0, ERROR}, 64'd0);
  endtask

  // delay: ACCESS cycle (1-based) in which ACK is given; 0 = never
  // rst_after: if nonzero, assert RST in that ACCESS cycle instead of completing
  task automatic run_tx(input logic [4:0] ctrl, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] wr, input logic [31:0] tgt, input logic zero,
                        input logic hit, input int delay, input logic [31:0] rdata,
                        input int rst_after);
    exp_t e;
    bit   is_mem, mis, is_load, err_tx, did_rst;
    int   reqs, cyc, exp_reqs;
    is_mem  = ctrl[1] | ctrl[0];
    is_load = ctrl[1] & ~ctrl[0];
    mis     = (addr % 4) != 0;
    err_tx  = 1'b0;
    e.rd    = 32'd0;
    if (is_mem) begin
      if (mis) err_tx = 1'b1;
      else if (delay >= 1 && delay <= TO) e.rd = is_load ? rdata : 32'd0;
      else err_tx = 1'b1;
    end
    exp_reqs = (delay >= 1 && delay <= TO) ? delay : TO;
    e.alu = addr;
    e.wr  = wr;
    e.ctl = {ctrl[4] & ~err_tx, ctrl[3]};
    e.pc  = ctrl[2] & zero;
    e.tgt = tgt;
    e.hit = hit;
    if (rst_after == 0) begin
      err_model = err_model | err_tx;
      e.err = err_model;
      sb.push_back(e);
    end

    chk("stall_before_issue", {63'd0, STALL}, 64'd0);
    IN_VALID = 1'b1; CONTROL = ctrl; ALU_RESULT = addr; WRITE_DATA = wdata;
    WRITE_REGISTER = wr; BRANCH_TARGET = tgt; ZERO = zero; HIT = hit;
    @(posedge CLK); @(negedge CLK);
    // scramble the EX outputs so the latched copies are what gets used
    IN_VALID = 1'b0; CONTROL = 5'($urandom); ALU_RESULT = $urandom; WRITE_DATA = $urandom;
    WRITE_REGISTER = 5'($urandom); BRANCH_TARGET = $urandom; ZERO = 1'($urandom); HIT = 1'($urandom);

    if (is_mem && !mis) begin
      reqs = 0; cyc = 0; did_rst = 1'b0;
      while (MEM_REQ === 1'b1 && cyc < 40) begin
        reqs++;
        if (reqs == 1) begin
          chk("mem_addr", {32'd0, MEM_ADDR}, {32'd0, addr});
          chk("mem_we", {63'd0, MEM_WE}, {63'd0, ctrl[0]});
          if (ctrl[0]) chk("mem_wdata", {32'd0, MEM_WDATA}, {32'd0, wdata});
          chk("stall_in_access", {63'd0, STALL}, 64'd1);
        end
        if (rst_after != 0 && reqs == rst_after) begin
          RST = 1'b1;
          @(posedge CLK); @(negedge CLK);
          RST = 1'b0;
          did_rst = 1'b1;
          err_model = 1'b0;
          chk("req_after_rst", {62'd0, MEM_REQ, STALL}, 64'd0);
        end else begin
          MEM_ACK   = (reqs == delay);
          MEM_RDATA = (reqs == delay) ? rdata : $urandom;
          @(posedge CLK); @(negedge CLK);
          MEM_ACK = 1'b0;
        end
        cyc++;
      end
      if (!did_rst) chk("req_cycles", 64'(reqs), 64'(exp_reqs));
    end else begin
      chk("no_req_no_stall", {62'd0, MEM_REQ, STALL}, 64'd0);
      if ($urandom_range(0, 3) == 0) begin
        // stray ACK while idle must be ignored
        MEM_ACK = 1'b1; MEM_RDATA = $urandom;
        @(posedge CLK); @(negedge CLK);
        MEM_ACK = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  c;
    logic [31:0] a;
    int          d;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_outputs",
        {2'd0, STALL, MEM_REQ, MEM_WE, OUT_VALID, PC_SRC, ERROR, HIT_OUT, WRITE_REG_OUT,
         CONTROL_OUT, READ_DATA[15:0], ALU_RESULT_OUT[15:0], MEM_ADDR[15:0]}, 64'd0);
    chk("reset_wide", {READ_DATA, BRANCH_TGT_OUT | MEM_WDATA | ALU_RESULT_OUT | MEM_ADDR}, 64'd0);
    RST = 1'b0;
    mon_en = 1'b1;
    @(negedge CLK);

    // directed
    run_tx(5'b10000, 32'h2A, 32'h0, 5'd3, 32'h0, 1'b0, 1'b1, 0, 32'h0, 0);          // ADD
    run_tx(5'b11010, 32'h100, 32'h0, 5'd7, 32'h0, 1'b0, 1'b0, 3, 32'hDEADBEEF, 0);  // LW
    run_tx(5'b00001, 32'h40, 32'h1234, 5'd0, 32'h0, 1'b0, 1'b1, 1, 32'h5555, 0);    // SW
    run_tx(5'b00100, 32'h0, 32'h0, 5'd0, 32'h80, 1'b1, 1'b0, 0, 32'h0, 0);          // BEQ taken
    run_tx(5'b00100, 32'h4, 32'h0, 5'd0, 32'h80, 1'b0, 1'b0, 0, 32'h0, 0);          // BEQ not taken
    run_tx(5'b11011, 32'h200, 32'h77, 5'd9, 32'h0, 1'b0, 1'b0, 2, 32'hCAFE, 0);     // both -> store
    run_tx(5'b11010, 32'h104, 32'h0, 5'd5, 32'h0, 1'b0, 1'b0, TO, 32'hA5A5A5A5, 0); // ACK on limit
    run_tx(5'b11010, 32'h108, 32'h0, 5'd6, 32'h0, 1'b0, 1'b1, 0, 32'h0, 0);         // timeout
    run_tx(5'b10000, 32'h11, 32'h0, 5'd2, 32'h0, 1'b0, 1'b0, 0, 32'h0, 0);          // ERROR sticky
    do_reset();
    run_tx(5'b11010, 32'h102, 32'h0, 5'd4, 32'h0, 1'b0, 1'b0, 1, 32'h1, 0);         // misaligned
    do_reset();
    run_tx(5'b11010, 32'h300, 32'h0, 5'd8, 32'h0, 1'b0, 1'b0, 0, 32'h0, 5);         // RST mid-access
    repeat (2) @(negedge CLK);

    // randomized
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: c = 5'b10000;
        1: c = 5'b11010;
        2: c = 5'b00001;
        3: c = 5'b00100;
        default: c = 5'($urandom);
      endcase
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      case ($urandom_range(0, 9))
        0: d = 0;
        1: d = TO;
        2: d = TO + 1;
        default: d = $urandom_range(1, 5);
      endcase
      run_tx(c, a, $urandom, 5'($urandom), $urandom, 1'($urandom), 1'($urandom),
             d, $urandom, 0);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      if ($urandom_range(0, 19) == 0) do_reset();
    end

    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
